// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared defaults and width helper for the round-robin arbitrated mux
package arb_mux_pkg;

  localparam int BITS_DEF     = 32;
  localparam int CHANNELS_DEF = 8;

  // Width of a channel index; a 2-channel build still needs one bit.
  function automatic int sel_width(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - circular first-requester search starting after the last winner
module rr_priority_select
  import arb_mux_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [SEL_W-1:0]    winner_o,
  output logic                any_o
);

  // Walk from farthest (ptr itself) to nearest (ptr+1) so the nearest requester overwrites.
  // The modulo keeps non-power-of-two channel counts wrapping from CHANNELS-1 to 0.
  always_comb begin
    int idx;
    logic [SEL_W-1:0] idx_s;
    winner_o = '0;
    any_o    = |req_i;
    for (int off = CHANNELS; off >= 1; off--) begin
      idx   = (int'(ptr_i) + off) % CHANNELS;
      idx_s = SEL_W'(idx);
      if (req_i[idx_s]) begin
        winner_o = idx_s;
      end
    end
    grant_o = any_o ? (CHANNELS'(1) << winner_o) : '0;
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// rtl/rr_arbiter_mux.sv - N-channel round-robin arbitrated mux with registered output (optional burst lock: ARB_MUX_LOCK_EN)
module rr_arbiter_mux
  import arb_mux_pkg::*;
#(
  parameter  int BITS     = BITS_DEF,
  parameter  int CHANNELS = CHANNELS_DEF,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [CHANNELS-1:0][BITS-1:0]  DATA,
  input  logic [CHANNELS-1:0]            VALID,
  output logic [CHANNELS-1:0]            READY,
  output logic [BITS-1:0]                OUT,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [SEL_W-1:0]               GRANT_ID
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]            LOCK
`endif
);

  logic [BITS-1:0]     out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic [CHANNELS-1:0] sel_grant;
  logic [SEL_W-1:0]    sel_winner;
  logic                sel_any;
  logic [CHANNELS-1:0] win_onehot;
  logic [SEL_W-1:0]    winner;
  logic                load;
  logic                xfer;

  rr_priority_select #(
    .CHANNELS (CHANNELS)
  ) u_sel (
    .req_i    (VALID),
    .ptr_i    (ptr_q),
    .grant_o  (sel_grant),
    .winner_o (sel_winner),
    .any_o    (sel_any)
  );

  // The output register can take a beat when it is empty or being drained this cycle.
  assign load = !out_valid_q || OUT_READY;

`ifdef ARB_MUX_LOCK_EN
  logic lock_hit;

  // A locked last winner that still requests keeps the path for its burst.
  always_comb begin
    lock_hit   = LOCK[ptr_q] && VALID[ptr_q];
    winner     = lock_hit ? ptr_q : sel_winner;
    win_onehot = lock_hit ? (CHANNELS'(1) << ptr_q) : sel_grant;
  end
`else
  // Pure rotation: the selector result is the winner.
  always_comb begin
    winner     = sel_winner;
    win_onehot = sel_grant;
  end
`endif

  assign READY = (load && sel_any && !RST) ? win_onehot : '0;
  assign xfer  = load && sel_any && !RST;

  // Next state: load the winner's beat, drain to empty when idle, otherwise hold.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_d       = DATA[winner];
      out_valid_d = 1'b1;
      grant_d     = winner;
      ptr_d       = winner;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage and rotation pointer; reset leaves channel 0 with first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign GRANT_ID  = grant_q;

  // Upstream must hold a pending request with stable payload until it is taken.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_hold_chk
    assert property (@(posedge CLK) disable iff (RST)
                     (VALID[g] && !READY[g]) |=> (VALID[g] && $stable(DATA[g])))
      else $error("channel %0d dropped or changed a pending request", g);
  end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// tb/tb_rr_arbiter_mux.sv - scoreboard bench for rr_arbiter_mux (8- and 5-channel instances)
module tb_rr_arbiter_mux;

  typedef struct {
    int          gid;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [7:0]        valid8, ready8, fire8;
  logic [7:0][31:0]  data8;
  logic [31:0]       out8;
  logic              ov8, ordy8;
  logic [2:0]        gid8;
  logic [4:0]        valid5, ready5, fire5;
  logic [4:0][31:0]  data5;
  logic [31:0]       out5;
  logic              ov5, ordy5;
  logic [2:0]        gid5;
`ifdef ARB_MUX_LOCK_EN
  logic [7:0]        lock8;
  logic [4:0]        lock5;
`endif

  logic [31:0] src8 [8][$];
  logic [31:0] src5 [5][$];
  beat_t       exp8 [$];
  beat_t       exp5 [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  rr_arbiter_mux #(.BITS(32), .CHANNELS(8)) u_dut8 (
    .CLK       (clk),
    .RST       (rst),
    .DATA      (data8),
    .VALID     (valid8),
    .READY     (ready8),
    .OUT       (out8),
    .OUT_VALID (ov8),
    .OUT_READY (ordy8),
    .GRANT_ID  (gid8)
`ifdef ARB_MUX_LOCK_EN
    ,
    .LOCK      (lock8)
`endif
  );

  rr_arbiter_mux #(.BITS(32), .CHANNELS(5)) u_dut5 (
    .CLK       (clk),
    .RST       (rst),
    .DATA      (data5),
    .VALID     (valid5),
    .READY     (ready5),
    .OUT       (out5),
    .OUT_VALID (ov5),
    .OUT_READY (ordy5),
    .GRANT_ID  (gid5)
`ifdef ARB_MUX_LOCK_EN
    ,
    .LOCK      (lock5)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh8();
    for (int i = 0; i < 8; i++) begin
      valid8[i] = (src8[i].size() != 0);
      data8[i]  = (src8[i].size() != 0) ? src8[i][0] : 32'h0;
    end
  endtask

  task automatic refresh5();
    for (int i = 0; i < 5; i++) begin
      valid5[i] = (src5[i].size() != 0);
      data5[i]  = (src5[i].size() != 0) ? src5[i][0] : 32'h0;
    end
  endtask

  task automatic push8(input int ch, input logic [31:0] d);
    src8[ch].push_back(d);
  endtask

  task automatic expect8(input int ch, input logic [31:0] d);
    beat_t b;
    b.gid = ch; b.data = d;
    exp8.push_back(b);
  endtask

  task automatic expect5(input int ch, input logic [31:0] d);
    beat_t b;
    b.gid = ch; b.data = d;
    exp5.push_back(b);
  endtask

  // Source model: a channel pops its head beat on the edge where it was accepted.
  always @(negedge clk) begin
    fire8 = valid8 & ready8;
    fire5 = valid5 & ready5;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 8; i++) if (fire8[i]) void'(src8[i].pop_front());
    for (int i = 0; i < 5; i++) if (fire5[i]) void'(src5[i].pop_front());
    refresh8();
    refresh5();
  end

  // Monitor: every beat leaving a DUT is matched against the scoreboard.
  always @(negedge clk) begin
    beat_t b;
    check("ready8_onehot0", 32'($countones(ready8) <= 1), 32'd1);
    check("ready5_onehot0", 32'($countones(ready5) <= 1), 32'd1);
    if (ov8 && ordy8 && !rst) begin
      if (exp8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut8_unexpected: got beat %0h from ch %0d, expected none", out8, gid8);
      end else begin
        b = exp8.pop_front();
        check("dut8_grant", 32'(gid8), b.gid);
        check("dut8_data", out8, b.data);
      end
    end
    if (ov5 && ordy5 && !rst) begin
      check("dut5_grant_range", 32'(gid5 < 3'd5), 32'd1);
      if (exp5.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut5_unexpected: got beat %0h from ch %0d, expected none", out5, gid5);
      end else begin
        b = exp5.pop_front();
        check("dut5_grant", 32'(gid5), b.gid);
        check("dut5_data", out5, b.data);
      end
    end
  end

  task automatic drain8(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp8.size() == 0) break;
    end
    check({name, "_drained"}, 32'(exp8.size()), 32'd0);
    exp8.delete();
    @(posedge clk); #1;
  endtask

  task automatic drain5(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp5.size() == 0) break;
    end
    check({name, "_drained"}, 32'(exp5.size()), 32'd0);
    exp5.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ordy8 = 1'b1; ordy5 = 1'b1;
    valid8 = '0; data8 = '0; valid5 = '0; data5 = '0;
    fire8 = '0; fire5 = '0;
`ifdef ARB_MUX_LOCK_EN
    lock8 = '0; lock5 = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    check("rst_out8", out8, 32'd0);
    check("rst_gid8", 32'(gid8), 32'd0);
    check("rst_ready8", 32'(ready8), 32'd0);
    check("rst_out_valid5", 32'(ov5), 32'd0);
    check("rst_out5", out5, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // All channels requesting, DATA[i]=i, one extra beat on channel 0.
    for (int i = 0; i < 8; i++) begin
      push8(i, 32'(i));
      expect8(i, 32'(i));
    end
    push8(0, 32'h100);
    expect8(0, 32'h100);
    refresh8();
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("throughput_valid", 32'(ov8), 32'd1);
    end
    @(negedge clk);
    check("idle_out_valid", 32'(ov8), 32'd0);
    check("idle_out_hold", out8, 32'h100);
    check("idle_gid_hold", 32'(gid8), 32'd0);
    drain8("all_valid", 20);

    // Only channels 2 and 5 requesting.
    push8(2, 32'h20); push8(2, 32'h21);
    push8(5, 32'h50); push8(5, 32'h51);
    expect8(2, 32'h20); expect8(5, 32'h50);
    expect8(2, 32'h21); expect8(5, 32'h51);
    refresh8();
    drain8("two_channel", 20);

    // Stall with 0xA5 held; pointer must stay on channel 1.
    ordy8 = 1'b0;
    push8(1, 32'hA5); push8(1, 32'hB6); push8(3, 32'h33);
    expect8(1, 32'hA5); expect8(3, 32'h33); expect8(1, 32'hB6);
    refresh8();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_out", out8, 32'hA5);
      check("stall_gid", 32'(gid8), 32'd1);
      check("stall_ready", 32'(ready8), 32'd0);
      check("stall_valid", 32'(ov8), 32'd1);
    end
    @(posedge clk); #1;
    ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("no_bubble_valid", 32'(ov8), 32'd1);
    check("no_bubble_gid", 32'(gid8), 32'd3);
    drain8("stall", 20);

    // Five channels: pointer wraps 4 -> 0.
    for (int i = 0; i < 5; i++) begin
      src5[i].push_back(32'(i));
      expect5(i, 32'(i));
    end
    src5[0].push_back(32'h100);
    expect5(0, 32'h100);
    refresh5();
    drain5("five_channel", 20);

    // Reset while a beat is pending; afterwards channel 0 must beat channel 6.
    ordy8 = 1'b0;
    push8(4, 32'h40); push8(6, 32'h60); push8(0, 32'hC0);
    refresh8();
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_out", out8, 32'h40);
    check("pre_rst_valid", 32'(ov8), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    ordy8 = 1'b1;
    @(negedge clk);
    check("rst_high_ready", 32'(ready8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(ov8), 32'd0);
    check("mid_rst_out", out8, 32'd0);
    check("mid_rst_gid", 32'(gid8), 32'd0);
    expect8(0, 32'hC0); expect8(6, 32'h60);
    @(posedge clk); #1;
    rst = 1'b0;
    drain8("after_reset", 20);

`ifdef ARB_MUX_LOCK_EN
    // Channel 3 locks after its first grant; releasing lets channel 1 in.
    lock8 = 8'b0000_1000;
    push8(1, 32'h10); push8(1, 32'h11);
    for (int k = 0; k < 5; k++) push8(3, 32'h30 + 32'(k));
    expect8(1, 32'h10); expect8(3, 32'h30); expect8(3, 32'h31); expect8(3, 32'h32);
    expect8(1, 32'h11); expect8(3, 32'h33); expect8(3, 32'h34);
    refresh8();
    repeat (4) @(posedge clk);
    #1;
    lock8 = '0;
    drain8("lock", 20);
`endif

    check("exp8_empty", 32'(exp8.size()), 32'd0);
    check("exp5_empty", 32'(exp5.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
